// File: rtl/spi_flash_read_engine.sv
// SPI flash single-word READ (0x03) engine, SPI mode 0.
// Shifts out opcode+address, captures a 32-bit word and returns it with a one-cycle read_done strobe.
module spi_flash_read_engine #(
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [7:0]  CMD_READ = 8'h03,
  parameter int unsigned T_DESEL  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read_valid,
  input  logic [23:0] paddr_valid,
  output logic [31:0] prdata_valid,
  output logic        read_done,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned HC_W   = 8;
  localparam int unsigned BC_W   = 7;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned N_BITS = 64;

  localparam logic [HC_W-1:0] HALF_RELOAD  = HC_W'(CLK_DIV - 1);
  localparam logic [HC_W-1:0] DESEL_RELOAD = HC_W'(T_DESEL - 1);
  localparam logic [BC_W-1:0] LAST_BIT     = BC_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DESEL = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [HC_W-1:0]     half_cnt, half_cnt_nxt;
  logic [BC_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [WORD_W-1:0]   tx_shift, tx_shift_nxt;
  logic [WORD_W-1:0]   rx_shift, rx_shift_nxt;
  logic [WORD_W-1:0]   prdata_nxt;
  logic                cs_n_nxt, sclk_nxt, mosi_nxt, done_nxt, busy_nxt;
  logic                phase_end;

  // half_cnt counts remaining cycles of the current phase; zero marks its last cycle
  assign phase_end = (half_cnt == '0);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      half_cnt     <= '0;
      bit_cnt      <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      prdata_valid <= '0;
      read_done    <= 1'b0;
      busy         <= 1'b0;
      spi_cs_n     <= 1'b1;
      spi_sclk     <= 1'b0;
      spi_mosi     <= 1'b0;
    end else begin
      state        <= state_nxt;
      half_cnt     <= half_cnt_nxt;
      bit_cnt      <= bit_cnt_nxt;
      tx_shift     <= tx_shift_nxt;
      rx_shift     <= rx_shift_nxt;
      prdata_valid <= prdata_nxt;
      read_done    <= done_nxt;
      busy         <= busy_nxt;
      spi_cs_n     <= cs_n_nxt;
      spi_sclk     <= sclk_nxt;
      spi_mosi     <= mosi_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (read_valid) state_nxt = SETUP;
      SETUP:   if (phase_end) state_nxt = SHIFT;
      SHIFT:   if (phase_end && spi_sclk && (bit_cnt == LAST_BIT)) state_nxt = HOLD;
      HOLD:    if (phase_end) state_nxt = DESEL;
      DESEL:   if (phase_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    half_cnt_nxt = half_cnt;
    bit_cnt_nxt  = bit_cnt;
    tx_shift_nxt = tx_shift;
    rx_shift_nxt = rx_shift;
    prdata_nxt   = prdata_valid;
    cs_n_nxt     = spi_cs_n;
    sclk_nxt     = spi_sclk;
    mosi_nxt     = spi_mosi;
    done_nxt     = 1'b0;
    busy_nxt     = (state_nxt != IDLE);
    case (state)
      IDLE: begin
        if (read_valid) begin
          tx_shift_nxt = {CMD_READ, paddr_valid};
          rx_shift_nxt = '0;
          half_cnt_nxt = HALF_RELOAD;
          bit_cnt_nxt  = '0;
          cs_n_nxt     = 1'b0;
          sclk_nxt     = 1'b0;
          mosi_nxt     = CMD_READ[7];
        end
      end
      SETUP: begin
        half_cnt_nxt = phase_end ? HALF_RELOAD : half_cnt - HC_W'(1);
      end
      SHIFT: begin
        if (phase_end) begin
          half_cnt_nxt = HALF_RELOAD;
          if (!spi_sclk) begin
            sclk_nxt     = 1'b1;
            rx_shift_nxt = {rx_shift[WORD_W-2:0], spi_miso};
          end else begin
            // tx_shift drains to zero after 32 shifts, so MOSI idles low for the data phase
            sclk_nxt     = 1'b0;
            tx_shift_nxt = {tx_shift[WORD_W-2:0], 1'b0};
            mosi_nxt     = tx_shift[WORD_W-2];
            bit_cnt_nxt  = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BC_W'(1);
          end
        end else begin
          half_cnt_nxt = half_cnt - HC_W'(1);
        end
      end
      HOLD: begin
        if (phase_end) begin
          half_cnt_nxt = DESEL_RELOAD;
          cs_n_nxt     = 1'b1;
          prdata_nxt   = rx_shift;
          done_nxt     = 1'b1;
        end else begin
          half_cnt_nxt = half_cnt - HC_W'(1);
        end
      end
      DESEL: begin
        if (!phase_end) half_cnt_nxt = half_cnt - HC_W'(1);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_read_engine.sv
// Bench for spi_flash_read_engine: two instances (CLK_DIV 2 and 1) with a flash model,
// a cycle-accurate transaction model and a queue-based scoreboard.
`timescale 1ns/1ps
module tb_spi_flash_read_engine;

  localparam int unsigned N_DUT   = 2;
  localparam int unsigned DIV0    = 2;
  localparam int unsigned DIV1    = 1;
  localparam int unsigned T_DESEL = 4;

  typedef struct {
    logic [23:0] addr;
    logic [31:0] data;
    int unsigned s;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n      [N_DUT];
  logic        read_valid [N_DUT];
  logic [23:0] paddr      [N_DUT];
  logic [31:0] prdata     [N_DUT];
  logic        read_done  [N_DUT];
  logic        busy       [N_DUT];
  logic        spi_cs_n   [N_DUT];
  logic        spi_sclk   [N_DUT];
  logic        spi_mosi   [N_DUT];
  logic        spi_miso   [N_DUT] = '{1'b0, 1'b0};

  req_t        exp_q [N_DUT][$];
  int unsigned idle_from [N_DUT];
  int unsigned edge_n = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic        end_chk = 1'b0;

  spi_flash_read_engine #(.CLK_DIV(DIV0), .CMD_READ(8'h03), .T_DESEL(T_DESEL)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .read_valid(read_valid[0]), .paddr_valid(paddr[0]),
    .prdata_valid(prdata[0]), .read_done(read_done[0]), .busy(busy[0]),
    .spi_cs_n(spi_cs_n[0]), .spi_sclk(spi_sclk[0]), .spi_mosi(spi_mosi[0]), .spi_miso(spi_miso[0])
  );

  spi_flash_read_engine #(.CLK_DIV(DIV1), .CMD_READ(8'h03), .T_DESEL(T_DESEL)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .read_valid(read_valid[1]), .paddr_valid(paddr[1]),
    .prdata_valid(prdata[1]), .read_done(read_done[1]), .busy(busy[1]),
    .spi_cs_n(spi_cs_n[1]), .spi_sclk(spi_sclk[1]), .spi_mosi(spi_mosi[1]), .spi_miso(spi_miso[1])
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  function automatic int unsigned div_of(input int g);
    return (g == 0) ? DIV0 : DIV1;
  endfunction

  function automatic void check(input string name, input int g,
                                input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", name, g, edge_n, act, exp);
    end
  endfunction

  // Monitor: flash model, per-cycle pin model, scoreboard pop and protocol rules
  logic        prev_sclk [N_DUT] = '{1'b0, 1'b0};
  logic        prev_cs   [N_DUT] = '{1'b1, 1'b1};
  logic        prev_mosi [N_DUT] = '{1'b0, 1'b0};
  logic        prev_done [N_DUT] = '{1'b0, 1'b0};
  int unsigned rise_cnt  [N_DUT] = '{0, 0};
  logic [31:0] cmd_cap   [N_DUT] = '{32'h0, 32'h0};
  logic [31:0] exp_prdata [N_DUT] = '{32'h0, 32'h0};
  int unsigned busy_until [N_DUT] = '{0, 0};
  logic        end_done = 1'b0;

  initial begin
    req_t        r;
    logic        active, e_cs_low, e_sclk, e_mosi, e_busy;
    int unsigned d, o, b, k;
    logic [31:0] word;
    forever begin
      @(negedge clk);
      for (int g = 0; g < int'(N_DUT); g++) begin
        d = div_of(g);
        if (!rst_n[g]) begin
          check("rst_cs_n", g, 64'(spi_cs_n[g]), 64'(1));
          check("rst_sclk", g, 64'(spi_sclk[g]), 64'(0));
          check("rst_mosi", g, 64'(spi_mosi[g]), 64'(0));
          check("rst_done", g, 64'(read_done[g]), 64'(0));
          check("rst_busy", g, 64'(busy[g]), 64'(0));
          check("rst_prdata", g, 64'(prdata[g]), 64'(0));
          exp_q[g].delete();
          busy_until[g] = 0;
          exp_prdata[g] = 32'h0;
          rise_cnt[g] = 0;
          cmd_cap[g] = 32'h0;
          prev_sclk[g] = 1'b0;
          prev_cs[g] = 1'b1;
          prev_mosi[g] = 1'b0;
          prev_done[g] = 1'b0;
          continue;
        end
        active = (exp_q[g].size() > 0) && (edge_n >= exp_q[g][0].s);
        e_cs_low = 1'b0;
        e_sclk = 1'b0;
        e_mosi = 1'b0;
        o = 0;
        if (active) begin
          o = edge_n - exp_q[g][0].s;
          word = {8'h03, exp_q[g][0].addr};
          e_cs_low = (o < 130 * d);
          if (o >= d && o < 129 * d) e_sclk = (((o - d) % (2 * d)) >= d);
          b = (o < d) ? 0 : (o - d) / (2 * d);
          if (b < 32) e_mosi = word[5'(31 - b)];
          e_busy = (o < 130 * d + T_DESEL);
        end else begin
          e_busy = (edge_n < busy_until[g]);
        end
        check("cs_n", g, 64'(spi_cs_n[g]), 64'(!e_cs_low));
        check("sclk", g, 64'(spi_sclk[g]), 64'(e_sclk));
        check("mosi", g, 64'(spi_mosi[g]), 64'(e_mosi));
        check("busy", g, 64'(busy[g]), 64'(e_busy));

        if (spi_sclk[g] && !prev_sclk[g]) begin
          check("mosi_stable_at_rise", g, 64'(spi_mosi[g]), 64'(prev_mosi[g]));
          check("rise_while_selected", g, 64'(spi_cs_n[g]), 64'(0));
          if (rise_cnt[g] < 32) cmd_cap[g] = {cmd_cap[g][30:0], spi_mosi[g]};
          rise_cnt[g]++;
        end
        if (!spi_sclk[g] && prev_sclk[g]) begin
          k = rise_cnt[g] - 1;
          if (active && k >= 31 && k <= 62) spi_miso[g] = exp_q[g][0].data[5'(62 - k)];
          else spi_miso[g] = 1'($urandom);
        end
        if (spi_cs_n[g] != prev_cs[g])
          check("sclk_low_at_cs_edge", g, 64'({spi_sclk[g], prev_sclk[g]}), 64'(0));
        if (read_done[g])
          check("done_single_cycle", g, 64'(prev_done[g]), 64'(0));

        if (read_done[g]) begin
          if (exp_q[g].size() == 0) begin
            check("unexpected_done", g, 64'(1), 64'(0));
          end else begin
            r = exp_q[g].pop_front();
            check("done_latency", g, 64'(edge_n), 64'(r.s + 130 * d));
            check("prdata", g, 64'(prdata[g]), 64'(r.data));
            check("mosi_frame", g, 64'(cmd_cap[g]), 64'({8'h03, r.addr}));
            check("sclk_rises", g, 64'(rise_cnt[g]), 64'(64));
            exp_prdata[g] = r.data;
            busy_until[g] = r.s + 130 * d + T_DESEL;
            rise_cnt[g] = 0;
            cmd_cap[g] = 32'h0;
          end
        end else if (active && o >= 130 * d) begin
          r = exp_q[g].pop_front();
          check("done_timeout", g, 64'(0), 64'(1));
          busy_until[g] = r.s + 130 * d + T_DESEL;
          rise_cnt[g] = 0;
          cmd_cap[g] = 32'h0;
        end
        check("prdata_hold", g, 64'(prdata[g]), 64'(exp_prdata[g]));

        prev_sclk[g] = spi_sclk[g];
        prev_cs[g] = spi_cs_n[g];
        prev_mosi[g] = spi_mosi[g];
        prev_done[g] = read_done[g];
      end
      if (end_chk && !end_done) begin
        for (int g = 0; g < int'(N_DUT); g++)
          check("queue_drained", g, 64'(exp_q[g].size()), 64'(0));
        end_done = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cycle(input int unsigned e);
    while (edge_n < e) step();
  endtask

  // Drive a one-cycle request; the reference model decides acceptance from idle_from
  task automatic request(input int g, input logic [23:0] a, input logic [31:0] d);
    req_t r;
    paddr[g] = a;
    read_valid[g] = 1'b1;
    if (edge_n >= idle_from[g]) begin
      r.addr = a;
      r.data = d;
      r.s = edge_n + 1;
      exp_q[g].push_back(r);
      idle_from[g] = r.s + 130 * div_of(g) + T_DESEL;
    end
    step();
    read_valid[g] = 1'b0;
    paddr[g] = 24'($urandom);
  endtask

  task automatic do_reset(input int g, input int unsigned n);
    rst_n[g] = 1'b0;
    read_valid[g] = 1'b0;
    repeat (n) step();
    rst_n[g] = 1'b1;
    idle_from[g] = edge_n;
  endtask

  initial begin
    int unsigned s0;
    int          g;
    for (int i = 0; i < int'(N_DUT); i++) begin
      rst_n[i] = 1'b0;
      read_valid[i] = 1'b0;
      paddr[i] = 24'h0;
      idle_from[i] = 0;
    end
    repeat (3) step();
    for (int i = 0; i < int'(N_DUT); i++) begin
      rst_n[i] = 1'b1;
      idle_from[i] = edge_n;
    end
    step();

    request(0, 24'h123456, 32'hDEADBEEF);
    goto_cycle(idle_from[0]);
    request(0, 24'h000004, 32'h01020304);
    goto_cycle(idle_from[0]);

    request(0, 24'h123456, 32'hCAFEF00D);
    s0 = idle_from[0] - 130 * DIV0 - T_DESEL;
    request(0, 24'hFFFFFF, 32'h11111111);
    goto_cycle(s0 + 2 + 40);
    request(0, 24'hFFFFFF, 32'h22222222);
    goto_cycle(s0 + 129 * DIV0);
    request(0, 24'hFFFFFF, 32'h33333333);
    goto_cycle(s0 + 130 * DIV0 + 1);
    request(0, 24'hFFFFFF, 32'h44444444);
    goto_cycle(idle_from[0]);

    request(0, 24'($urandom), $urandom);
    s0 = idle_from[0] - 130 * DIV0 - T_DESEL;
    goto_cycle(s0 + DIV0 + 2 * DIV0 * 40);
    do_reset(0, 2);
    step();
    request(0, 24'h0A0B0C, 32'h5A5AA5A5);
    goto_cycle(idle_from[0]);

    request(1, 24'hABCDEF, 32'h80000001);
    goto_cycle(idle_from[1]);

    for (int n = 0; n < 20; n++) begin
      g = int'($urandom_range(0, 1));
      goto_cycle(idle_from[g] + $urandom_range(0, 3));
      request(g, 24'($urandom), $urandom);
      if ($urandom_range(0, 1) == 1) begin
        goto_cycle(edge_n + $urandom_range(0, 300));
        request(g, 24'($urandom), $urandom);
      end
    end

    goto_cycle(((idle_from[0] > idle_from[1]) ? idle_from[0] : idle_from[1]) + 3);
    end_chk = 1'b1;
    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
